// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch with an in-order prefetch queue. The credit rule reserves queue space for every
// outstanding memory request. A redirect empties the queue and drains the stale responses still in flight.
module fetch_prefetch_unit #(
   parameter int              XLEN     = 32,
   parameter int              ILEN     = 32,
   parameter int              DEPTH    = 4,
   parameter int              PC_STEP  = 1,
   parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic                       imem_req_valid,
   output logic [XLEN-1:0]            imem_req_addr,
   input  logic                       imem_req_ready,
   input  logic                       imem_rsp_valid,
   input  logic [ILEN-1:0]            imem_rsp_inst,
   input  logic                       redirect_valid,
   input  logic [XLEN-1:0]            redirect_pc,
   output logic                       id_valid,
   output logic [ILEN-1:0]            id_inst,
   output logic [XLEN-1:0]            id_pc,
   input  logic                       id_ready,
   output logic [$clog2(DEPTH+1)-1:0] q_count
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [0:0] {ST_FETCH = 1'b0, ST_FLUSH = 1'b1} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_rsp_pc;
   logic [CW-1:0]   r_outstanding;
   logic [CW-1:0]   r_drop_cnt;
   logic [CW-1:0]   r_count;
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [XLEN-1:0] r_q_pc   [DEPTH];
   logic [ILEN-1:0] r_q_inst [DEPTH];

   logic            w_accept;
   logic            w_rsp;
   logic            w_push;
   logic            w_pop;
   logic            w_credit_ok;
   logic [CW:0]     w_inflight;
   logic [CW-1:0]   w_out_nxt;
   logic [CW-1:0]   w_drop_nxt;

   // A response only counts when a request is actually in flight, so stale traffic after reset is ignored.
   assign w_rsp       = imem_rsp_valid && (r_outstanding != {CW{1'b0}});
   assign w_accept    = imem_req_valid && imem_req_ready;
   assign w_push      = w_rsp && !redirect_valid && (r_state == ST_FETCH);
   assign w_pop       = id_valid && id_ready;
   assign w_inflight  = {1'b0, r_count} + {1'b0, r_outstanding};
   assign w_credit_ok = w_inflight < (CW+1)'(DEPTH);
   assign w_out_nxt   = r_outstanding + CW'(w_accept) - CW'(w_rsp);

   assign imem_req_addr = r_fetch_pc;
   assign id_pc         = r_q_pc[r_rd_ptr];
   assign id_inst       = r_q_inst[r_rd_ptr];
   assign q_count       = r_count;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and drop count; a redirect overrides whatever the current state would do
   always_comb begin
      w_state_nxt = r_state;
      w_drop_nxt  = r_drop_cnt;
      if (redirect_valid) begin
         w_drop_nxt  = w_out_nxt;
         w_state_nxt = (w_out_nxt != {CW{1'b0}}) ? ST_FLUSH : ST_FETCH;
      end else begin
         case (r_state)
            ST_FETCH: w_state_nxt = ST_FETCH;
            ST_FLUSH: begin
               if (w_rsp) begin
                  w_drop_nxt  = r_drop_cnt - CW'(1'b1);
                  w_state_nxt = (r_drop_cnt == CW'(1'b1)) ? ST_FETCH : ST_FLUSH;
               end else begin
                  w_state_nxt = ST_FLUSH;
               end
            end
            default: w_state_nxt = ST_FETCH;
         endcase
      end
   end

   // FSM outputs toward memory and decode
   always_comb begin
      imem_req_valid = 1'b0;
      id_valid       = (r_count != {CW{1'b0}}) && !redirect_valid;
      case (r_state)
         ST_FETCH: imem_req_valid = rst_n && !redirect_valid && w_credit_ok;
         ST_FLUSH: imem_req_valid = 1'b0;
         default:  imem_req_valid = 1'b0;
      endcase
   end

   // PCs, pointers and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc    <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_wr_ptr      <= {AW{1'b0}};
         r_rd_ptr      <= {AW{1'b0}};
         r_count       <= {CW{1'b0}};
         r_outstanding <= {CW{1'b0}};
         r_drop_cnt    <= {CW{1'b0}};
      end else begin
         r_outstanding <= w_out_nxt;
         r_drop_cnt    <= w_drop_nxt;
         if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_rsp_pc   <= redirect_pc;
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_count    <= {CW{1'b0}};
         end else begin
            if (w_accept) begin
               r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
            end
            if (w_push) begin
               r_rsp_pc <= r_rsp_pc + XLEN'(PC_STEP);
               r_wr_ptr <= r_wr_ptr + AW'(1'b1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + AW'(1'b1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   // Queue storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_q_pc[i]   <= {XLEN{1'b0}};
            r_q_inst[i] <= {ILEN{1'b0}};
         end
      end else if (w_push) begin
         r_q_pc[r_wr_ptr]   <= r_rsp_pc;
         r_q_inst[r_wr_ptr] <= imem_rsp_inst;
      end
   end
endmodule
